// File: rtl/mfp_ahb_lite_to_byte_stream_bridge_if.sv
// AHB-Lite slave bus plus the byte-stream valid/ready output of the program-loader bridge.
// The slave modport is the bridge; the master modport is whatever drives the bus and sinks bytes.
interface mfp_ahb_lite_to_byte_stream_bridge_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    logic [31:0] byte_address;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;

    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HBURST, HPROT, HMASTLOCK, HWDATA,
        output HRDATA, HREADY, HRESP,
        output byte_address, byte_data, byte_valid,
        input  byte_ready
    );

    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HBURST, HPROT, HMASTLOCK, HWDATA,
        input  HRDATA, HREADY, HRESP,
        input  byte_address, byte_data, byte_valid,
        output byte_ready
    );
endinterface

// File: rtl/mfp_ahb_lite_to_byte_stream_bridge.sv
// AHB-Lite write sink: buffers byte/halfword/word writes in a FIFO and replays each one as
// ascending single-byte writes on a valid/ready stream. Reads return a status word.
module mfp_ahb_lite_to_byte_stream_bridge #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] ADDR_MASK  = 32'h1FFF_FFFF
) (
    input  logic clock,
    input  logic reset_n,
    mfp_ahb_lite_to_byte_stream_bridge_if.slave bus,
    output logic debug_state
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // Byte stream: byte_valid=1 offers byte_address/byte_data; the byte is taken on a clock
    // edge where byte_valid && byte_ready. While byte_valid && !byte_ready everything is held.
    typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} ser_state_t;

    ser_state_t        state, state_next;
    logic [1:0]        idx, idx_next;
    logic [31:0]       w_addr;
    logic [1:0]        w_size;
    logic [31:0]       w_data;

    logic [31:0]       fifo_addr [FIFO_DEPTH];
    logic [1:0]        fifo_size [FIFO_DEPTH];
    logic [31:0]       fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  occupancy;
    logic              full, empty;

    logic              dp_valid, dp_write;
    logic [31:0]       dp_addr;
    logic [1:0]        dp_size;

    logic              hready;
    logic              addr_accept;
    logic [1:0]        size_eff;
    logic [31:0]       addr_aligned;
    logic              push, pop;
    logic              last_byte;
    logic [1:0]        lane;
    logic              unused_ahb_sideband;

    assign unused_ahb_sideband = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK};

    // Occupancy counts the entry being serialized, so a slot only frees once its last byte is taken.
    assign occupancy = fifo_count + CNT_W'(state == S_SEND);
    assign full      = (occupancy == CNT_W'(FIFO_DEPTH));
    assign empty     = (occupancy == '0);

    assign hready      = !(dp_valid && dp_write && full);
    assign addr_accept = bus.HSEL && bus.HTRANS[1] && hready;
    assign push        = dp_valid && dp_write && hready;

    always_comb begin
        size_eff     = (bus.HSIZE[2] || (bus.HSIZE[1:0] == 2'd3)) ? 2'd2 : bus.HSIZE[1:0];
        addr_aligned = bus.HADDR & ADDR_MASK;
        case (size_eff)
            2'd1:    addr_aligned[0]   = 1'b0;
            2'd2:    addr_aligned[1:0] = 2'b00;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= '0;
            dp_size  <= '0;
        end else if (hready) begin
            dp_valid <= addr_accept;
            dp_write <= bus.HWRITE;
            dp_addr  <= addr_aligned;
            dp_size  <= size_eff;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_addr[wr_ptr] <= dp_addr;
            fifo_size[wr_ptr] <= dp_size;
            fifo_data[wr_ptr] <= bus.HWDATA;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        case (w_size)
            2'd0:    last_byte = (idx == 2'd0);
            2'd1:    last_byte = (idx == 2'd1);
            default: last_byte = (idx == 2'd3);
        endcase
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                if (fifo_count != '0) begin
                    pop        = 1'b1;
                    idx_next   = 2'd0;
                    state_next = S_SEND;
                end
            end
            S_SEND: begin
                if (bus.byte_ready) begin
                    if (!last_byte) begin
                        idx_next = idx + 2'd1;
                    end else if (fifo_count != '0) begin
                        // Back-to-back: load the next entry without an idle bubble.
                        pop      = 1'b1;
                        idx_next = 2'd0;
                    end else begin
                        idx_next   = 2'd0;
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            idx    <= 2'd0;
            w_addr <= '0;
            w_size <= '0;
            w_data <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            if (pop) begin
                w_addr <= fifo_addr[rd_ptr];
                w_size <= fifo_size[rd_ptr];
                w_data <= fifo_data[rd_ptr];
            end
        end
    end

    assign lane             = w_addr[1:0] + idx;
    assign bus.byte_valid   = (state == S_SEND);
    assign bus.byte_address = (state == S_SEND) ? (w_addr + {30'b0, idx}) : 32'h0;
    assign bus.byte_data    = (state == S_SEND) ? w_data[{lane, 3'b000} +: 8] : 8'h00;

    assign bus.HREADY = hready;
    assign bus.HRESP  = 1'b0;
    assign bus.HRDATA = (dp_valid && !dp_write)
                      ? {16'b0, 8'(occupancy), 6'b0, full, empty}
                      : 32'h0;

    assign debug_state = state;

endmodule

// File: tb/tb_mfp_ahb_lite_to_byte_stream_bridge.sv
// Directed bench for the AHB-Lite to byte-stream bridge: table of single writes plus
// hand-written sequences for backpressure, FIFO-full wait states, status reads and reset.
module tb_mfp_ahb_lite_to_byte_stream_bridge;

    logic clock;
    logic reset_n;
    logic debug_state;

    mfp_ahb_lite_to_byte_stream_bridge_if bus ();

    mfp_ahb_lite_to_byte_stream_bridge #(
        .FIFO_DEPTH (4),
        .ADDR_MASK  (32'h1FFF_FFFF)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .bus         (bus),
        .debug_state (debug_state)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clock) cyc++;

    logic [39:0] exp_q[$];
    int          hs_cyc_q[$];
    int          hs_total        = 0;
    int          first_valid_cyc = -1;
    logic        hold_pending    = 1'b0;
    logic [31:0] hold_addr;
    logic [7:0]  hold_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Byte monitor and scoreboard: every accepted byte must match the head of exp_q, and an
    // unaccepted byte must be presented unchanged on the next cycle.
    always @(negedge clock) begin
        if (!reset_n) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending)
                check("hold_stable", {23'b0, bus.byte_valid, bus.byte_address, bus.byte_data},
                      {23'b0, 1'b1, hold_addr, hold_data});
            if (bus.byte_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (bus.byte_valid && bus.byte_ready) begin
                hs_total++;
                hs_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %0h/%0h expected none",
                             bus.byte_address, bus.byte_data);
                end else begin
                    check("byte", {24'b0, bus.byte_address, bus.byte_data}, {24'b0, exp_q.pop_front()});
                end
                hold_pending = 1'b0;
            end else if (bus.byte_valid) begin
                hold_pending = 1'b1;
                hold_addr    = bus.byte_address;
                hold_data    = bus.byte_data;
            end else begin
                hold_pending = 1'b0;
            end
        end
    end

    logic [31:0] tr_addr  [8];
    logic [2:0]  tr_size  [8];
    logic [31:0] tr_data  [8];
    logic        tr_write [8];
    int          tr_stall [8];
    int          tr_end_cyc [8];
    logic [31:0] tr_rdata [8];

    task automatic drive_idle();
        bus.HSEL      = 1'b0;
        bus.HTRANS    = 2'b00;
        bus.HADDR     = 32'h0;
        bus.HSIZE     = 3'd0;
        bus.HWRITE    = 1'b0;
        bus.HBURST    = 3'd0;
        bus.HPROT     = 4'b0011;
        bus.HMASTLOCK = 1'b0;
    endtask

    task automatic drive_addr(input int k);
        bus.HSEL   = 1'b1;
        bus.HTRANS = 2'b10;
        bus.HADDR  = tr_addr[k];
        bus.HSIZE  = tr_size[k];
        bus.HWRITE = tr_write[k];
    endtask

    // Pipelined AHB master: address phase of k overlaps data phase of k-1. Called at posedge+1.
    task automatic run_transfers(input int n);
        int   k;
        int   d;
        int   guard;
        logic rdy;
        k = 0;
        d = -1;
        guard = 0;
        for (int i = 0; i < n; i++) tr_stall[i] = 0;
        drive_addr(0);
        while ((k < n || d >= 0) && guard < 400) begin
            @(negedge clock);
            rdy = bus.HREADY;
            if (d >= 0) begin
                if (rdy) begin
                    tr_end_cyc[d] = cyc;
                    tr_rdata[d]   = bus.HRDATA;
                end else begin
                    tr_stall[d]++;
                end
            end
            @(posedge clock);
            #1;
            guard++;
            if (rdy) begin
                d = (k < n) ? k : -1;
                if (k < n) k++;
                if (k < n) drive_addr(k);
                else drive_idle();
                if (d >= 0) bus.HWDATA = tr_write[d] ? tr_data[d] : 32'h0;
            end
        end
        if (guard >= 400) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ahb_timeout: got no completion expected %0d transfers", n);
        end
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || bus.byte_valid) && guard < 300) begin
            @(posedge clock);
            #1;
            guard++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic read_status(input string name, input logic [31:0] exp);
        tr_addr[0]  = 32'h0000_0000;
        tr_size[0]  = 3'd2;
        tr_write[0] = 1'b0;
        tr_data[0]  = 32'h0;
        run_transfers(1);
        check(name, 64'(tr_rdata[0]), 64'(exp));
    endtask

    typedef struct {
        logic [31:0] haddr;
        logic [2:0]  hsize;
        logic [31:0] hwdata;
        logic [31:0] exp_base;
        int          exp_n;
        logic [31:0] exp_bytes;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] eb;
        int          base_hs;
        int          guard;

        vecs[0] = '{32'hBFC0_0000, 3'd2, 32'h4433_2211, 32'h1FC0_0000, 4, 32'h4433_2211};
        vecs[1] = '{32'h0000_0102, 3'd0, 32'h00AB_0000, 32'h0000_0102, 1, 32'h0000_00AB};
        vecs[2] = '{32'h0000_0101, 3'd1, 32'hDDCC_0000, 32'h0000_0100, 2, 32'h0000_0000};
        vecs[3] = '{32'hE000_0006, 3'd1, 32'h1234_5678, 32'h0000_0006, 2, 32'h0000_1234};
        vecs[4] = '{32'h2000_0013, 3'd3, 32'hA1B2_C3D4, 32'h0000_0010, 4, 32'hA1B2_C3D4};
        vecs[5] = '{32'h0000_0FFF, 3'd0, 32'h7700_0000, 32'h0000_0FFF, 1, 32'h0000_0077};

        reset_n        = 1'b0;
        drive_idle();
        bus.HWDATA     = 32'h0;
        bus.byte_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_hready",  64'(bus.HREADY), 64'd1);
        check("reset_hrdata",  64'(bus.HRDATA), 64'd0);
        check("reset_hresp",   64'(bus.HRESP), 64'd0);
        check("reset_valid",   64'(bus.byte_valid), 64'd0);
        check("reset_address", 64'(bus.byte_address), 64'd0);
        check("reset_data",    64'(bus.byte_data), 64'd0);
        check("reset_state",   64'(debug_state), 64'd0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Single writes into an empty bridge with the sink always ready.
        bus.byte_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            eb = vecs[v].exp_bytes;
            for (int i = 0; i < vecs[v].exp_n; i++)
                exp_q.push_back({vecs[v].exp_base + 32'(i), eb[8*i +: 8]});
            tr_addr[0]  = vecs[v].haddr;
            tr_size[0]  = vecs[v].hsize;
            tr_data[0]  = vecs[v].hwdata;
            tr_write[0] = 1'b1;
            first_valid_cyc = -1;
            run_transfers(1);
            drain("vec_drain");
            check("vec_wait_states", 64'(tr_stall[0]), 64'd0);
            check("vec_latency", 64'(first_valid_cyc - tr_end_cyc[0]), 64'd2);
        end

        // Five pipelined words with the sink stalled: the fifth data phase must wait.
        bus.byte_ready = 1'b0;
        hs_cyc_q.delete();
        for (int k = 0; k < 5; k++) begin
            tr_addr[k]  = 32'h4000_0000 + 32'(16 * k);
            tr_size[k]  = 3'd2;
            tr_write[k] = 1'b1;
            tr_data[k]  = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            for (int i = 0; i < 4; i++) exp_q.push_back({32'(16*k + i), 8'(4*k + i)});
        end
        fork
            run_transfers(5);
            begin
                repeat (12) @(posedge clock);
                #1;
                bus.byte_ready = 1'b1;
            end
        join
        for (int k = 0; k < 4; k++) check("full_zero_wait", 64'(tr_stall[k]), 64'd0);
        check("full_fifth_stalls", 64'(tr_stall[4] > 0), 64'd1);
        if (hs_cyc_q.size() >= 4)
            check("full_release_cycle", 64'(tr_end_cyc[4]), 64'(hs_cyc_q[3] + 1));
        else
            check("full_release_bytes", 64'(hs_cyc_q.size()), 64'd4);
        drain("full_drain");

        // Sink toggling every cycle during a word write.
        bus.byte_ready = 1'b0;
        tr_addr[0]  = 32'h0000_2000;
        tr_size[0]  = 3'd2;
        tr_data[0]  = 32'hDEAD_BEEF;
        tr_write[0] = 1'b1;
        exp_q.push_back({32'h0000_2000, 8'hEF});
        exp_q.push_back({32'h0000_2001, 8'hBE});
        exp_q.push_back({32'h0000_2002, 8'hAD});
        exp_q.push_back({32'h0000_2003, 8'hDE});
        fork
            run_transfers(1);
            begin
                for (int t = 0; t < 12; t++) begin
                    @(posedge clock);
                    #1;
                    bus.byte_ready = ~bus.byte_ready;
                end
            end
        join
        bus.byte_ready = 1'b1;
        drain("toggle_drain");

        // Status reads: two buffered, then full, then empty.
        bus.byte_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tr_addr[k]  = 32'h0000_3000 + 32'(4 * k);
            tr_size[k]  = 3'd2;
            tr_write[k] = 1'b1;
        end
        tr_data[0] = 32'h8765_4321;
        tr_data[1] = 32'h0FED_CBA9;
        exp_q.push_back({32'h0000_3000, 8'h21});
        exp_q.push_back({32'h0000_3001, 8'h43});
        exp_q.push_back({32'h0000_3002, 8'h65});
        exp_q.push_back({32'h0000_3003, 8'h87});
        exp_q.push_back({32'h0000_3004, 8'hA9});
        exp_q.push_back({32'h0000_3005, 8'hCB});
        exp_q.push_back({32'h0000_3006, 8'hED});
        exp_q.push_back({32'h0000_3007, 8'h0F});
        run_transfers(2);
        repeat (3) @(posedge clock);
        #1;
        check("status_state_send", 64'(debug_state), 64'd1);
        read_status("status_two", 32'h0000_0200);
        check("hrdata_idle_zero", 64'(bus.HRDATA), 64'd0);
        for (int k = 0; k < 2; k++) begin
            tr_addr[k]  = 32'h0000_3008 + 32'(4 * k);
            tr_size[k]  = 3'd0;
            tr_write[k] = 1'b1;
        end
        tr_data[0] = 32'h0000_0055;
        tr_data[1] = 32'h0000_0066;
        exp_q.push_back({32'h0000_3008, 8'h55});
        exp_q.push_back({32'h0000_300C, 8'h66});
        run_transfers(2);
        read_status("status_full", 32'h0000_0402);
        bus.byte_ready = 1'b1;
        drain("status_drain");
        read_status("status_empty", 32'h0000_0001);

        // Reset in the middle of a word, after two bytes went out.
        bus.byte_ready = 1'b1;
        base_hs     = hs_total;
        tr_addr[0]  = 32'h0000_5000;
        tr_size[0]  = 3'd2;
        tr_data[0]  = 32'h5566_7788;
        tr_write[0] = 1'b1;
        exp_q.push_back({32'h0000_5000, 8'h88});
        exp_q.push_back({32'h0000_5001, 8'h77});
        exp_q.push_back({32'h0000_5002, 8'h66});
        exp_q.push_back({32'h0000_5003, 8'h55});
        run_transfers(1);
        guard = 0;
        while (hs_total - base_hs < 2 && guard < 20) begin
            @(posedge clock);
            #1;
            guard++;
        end
        check("rst_two_bytes_out", 64'(hs_total - base_hs), 64'd2);
        check("rst_pre_valid", 64'(bus.byte_valid), 64'd1);
        reset_n = 1'b0;
        #1;
        check("rst_valid_drop", 64'(bus.byte_valid), 64'd0);
        check("rst_hready", 64'(bus.HREADY), 64'd1);
        exp_q.delete();
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        base_hs = hs_total;
        repeat (10) @(posedge clock);
        #1;
        check("rst_no_residual", 64'(hs_total - base_hs), 64'd0);
        check("rst_idle_valid", 64'(bus.byte_valid), 64'd0);
        read_status("rst_status", 32'h0000_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
